uart_rx_shift_register: RTL and testbench
=========================================

Name: uart_rx_shift_register

Overview:
Serial receive path that pairs with the Tx shift register and completes the UART link. It samples the serial line on an oversampling tick and detects the start bit. It then shifts in DATA_BITS data bits LSB first and checks the stop bit. A completed byte is presented on a held-valid / acknowledge handshake to the consuming controller, with framing and overrun error flags.

Parameters:
DATA_BITS, 8, number of data bits per frame (frame = 1 start bit 0, DATA_BITS data bits LSB first, 1 stop bit 1; idle line = 1)
OVERSAMPLE, 16, sample_tick pulses per bit period; even, >= 4

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
sample_tick  input  1  oversampling enable, one-cycle pulse, OVERSAMPLE per bit
bit_in  input  1  raw serial line, asynchronous to clk
rx_ack  input  1  consumer acknowledge; clears rx_done and error flags
data_received  output  DATA_BITS  last correctly framed byte
rx_done  output  1  byte available; held until rx_ack
framing_err  output  1  stop bit sampled as 0
overrun_err  output  1  new byte completed while rx_done still set
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on nrst. All state resets asynchronously.
- Reset values: data_received=0, rx_done=0, framing_err=0, overrun_err=0, busy=0. FSM=IDLE, tick and bit counters=0, shift register=0, synchronizer flops=1.
- bit_in passes through a 2-flop synchronizer reset to 1. All decisions use the synchronized line (line_s), adding 2 cycles of latency.
- The FSM and counters advance only on cycles with sample_tick=1. Otherwise they hold.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE, on tick with line_s=0: go to START, tick_cnt=0.
- START: tick_cnt increments each tick.
  - At tick_cnt==OVERSAMPLE/2-1 (mid start bit), sample line_s.
  - If 0: go to DATA, tick_cnt=0, bit_idx=0.
  - If 1: treat as a glitch and return to IDLE. No flags change.
- DATA: at tick_cnt==OVERSAMPLE-1, sample line_s into the MSB of the shift register (shift right), reset tick_cnt to 0, and increment bit_idx.
  - After the DATA_BITS-th sample, go to STOP.
- STOP: at tick_cnt==OVERSAMPLE-1, sample line_s.
  - If 1: data_received <= shift register, rx_done <= 1, go to IDLE. If rx_done was already 1 and rx_ack is not asserted that cycle, also set overrun_err <= 1; the new byte overwrites the old one.
  - If 0: framing_err <= 1, data_received and rx_done unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until a tick with line_s=1, then go to IDLE. This prevents a break condition from being read as repeated starts.
- Latency: outputs update on the clk edge of the stop-sampling tick cycle. rx_done is visible the following cycle.
- rx_ack: one cycle high clears rx_done, framing_err and overrun_err on the next edge.
  - If rx_ack coincides with a new valid completion, completion wins: rx_done stays 1, data is updated, overrun_err is not set, and framing_err is cleared.
  - If rx_ack coincides with a framing error, framing_err ends at 1.
- rx_ack while rx_done=0 has no effect except clearing error flags.
- Counter widths: tick_cnt is clog2(OVERSAMPLE) bits and bit_idx is clog2(DATA_BITS+1) bits. Neither ever wraps, because each is reset on state transitions.
- busy = (FSM != IDLE). It is combinational from state.
- nrst asserted mid-frame aborts immediately to reset values. A later frame must be received correctly without residue.

Test Plan:
1. Reset mid-frame: drive 0xD3 frame, assert nrst low during DATA, then release -> all outputs 0 and busy=0. A following frame of 0x5A is received correctly as data_received=0x5A.
2. Nominal: sample_tick every cycle, OVERSAMPLE=16, frame 0xD3 (line 0, then 1,1,0,0,1,0,1,1, then 1) -> data_received=0xD3, rx_done=1, framing_err=0. rx_ack pulse -> rx_done=0 next cycle with data held.
3. Glitch: line low for 4 ticks then high -> no rx_done, FSM back to IDLE (busy=0) at the mid-start sample.
4. Framing error: frame 0x55 with stop bit 0, line held low 20 more ticks, then high -> framing_err=1, rx_done=0, data_received unchanged, busy high until the line returns high.
5. Overrun: frames 0xA5 then 0x3C with no ack -> data_received=0x3C, rx_done=1, overrun_err=1. rx_ack clears both flags.
6. Ack collision: assert rx_ack exactly on the completion cycle of a second frame 0x81 -> rx_done=1, data_received=0x81, overrun_err=0.

Source files
------------

// File: rtl/uart_rx_shift_register.sv
// UART receive shift register: synchronizes the serial line, finds the start bit on the
// oversampling tick, shifts in DATA_BITS LSB-first, checks the stop bit and hands the byte over.
module uart_rx_shift_register #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 sample_tick,
    input  logic                 bit_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] data_received,
    output logic                 rx_done,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   w_line_s;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic [TICK_W-1:0]      w_tick_nxt;
    logic [BIT_W-1:0]       r_bit_idx;
    logic [BIT_W-1:0]       w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic                   w_complete;
    logic                   w_frame_err;

    assign w_line_s = r_sync2;
    assign busy     = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_complete  = 1'b0;
        w_frame_err = 1'b0;
        if (sample_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_line_s) begin
                        w_state_nxt = S_START;
                        w_tick_nxt  = '0;
                    end
                end
                S_START: begin
                    if (r_tick_cnt == TICK_MID) begin
                        // A start bit that is high again by its midpoint was only a glitch
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = w_line_s ? S_IDLE : S_DATA;
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == TICK_END) begin
                        w_shift_nxt = {w_line_s, r_shift[DATA_BITS-1:1]};
                        w_tick_nxt  = '0;
                        w_bit_nxt   = r_bit_idx + BIT_W'(1);
                        if (r_bit_idx == BIT_LAST) begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_tick_cnt == TICK_END) begin
                        w_tick_nxt = '0;
                        if (w_line_s) begin
                            w_complete  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_frame_err = 1'b1;
                            w_state_nxt = S_WAIT_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_line_s) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_state       <= S_IDLE;
            r_tick_cnt    <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            data_received <= '0;
            rx_done       <= 1'b0;
            framing_err   <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            r_sync1    <= bit_in;
            r_sync2    <= r_sync1;
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            // A new completion beats a simultaneous ack; an ack only prevents the overrun
            if (w_complete) begin
                data_received <= r_shift;
                rx_done       <= 1'b1;
                if (rx_ack) begin
                    framing_err <= 1'b0;
                    overrun_err <= 1'b0;
                end else if (rx_done) begin
                    overrun_err <= 1'b1;
                end
            end else if (w_frame_err) begin
                framing_err <= 1'b1;
                if (rx_ack) begin
                    rx_done     <= 1'b0;
                    overrun_err <= 1'b0;
                end
            end else if (rx_ack) begin
                rx_done     <= 1'b0;
                framing_err <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_shift_register.sv
// Bench for uart_rx_shift_register: table of frames, directed corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_shift_register;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int FRAME_BITS = DATA_BITS + 2;

    logic                 clk;
    logic                 nrst;
    logic                 sample_tick;
    logic                 bit_in;
    logic                 rx_ack;
    logic [DATA_BITS-1:0] data_received;
    logic                 rx_done;
    logic                 framing_err;
    logic                 overrun_err;
    logic                 busy;

    int total;
    int bad;
    bit gaps_en;

    uart_rx_shift_register #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .sample_tick  (sample_tick),
        .bit_in       (bit_in),
        .rx_ack       (rx_ack),
        .data_received(data_received),
        .rx_done      (rx_done),
        .framing_err  (framing_err),
        .overrun_err  (overrun_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       stop_b;
        logic       ack_before;
        logic [7:0] e_data;
        logic       e_done;
        logic       e_ferr;
        logic       e_oerr;
        logic       e_busy;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input logic done,
                           input logic ferr, input logic oerr, input logic bsy);
        chk({tag, ".data"}, 32'(data_received), 32'(d));
        chk({tag, ".rx_done"}, 32'(rx_done), 32'(done));
        chk({tag, ".framing_err"}, 32'(framing_err), 32'(ferr));
        chk({tag, ".overrun_err"}, 32'(overrun_err), 32'(oerr));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        sample_tick = 1'b0;
        rx_ack      = 1'b0;
    endtask

    task automatic do_tick(input logic b, input logic ack);
        if (gaps_en) begin
            int n;
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clk);
                bit_in      = b;
                sample_tick = 1'b0;
                rx_ack      = 1'b0;
            end
        end
        @(negedge clk);
        bit_in      = b;
        sample_tick = 1'b1;
        rx_ack      = ack;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        sample_tick = 1'b0;
        rx_ack      = 1'b1;
        @(negedge clk);
        rx_ack      = 1'b0;
    endtask

    // ack_idx selects the tick (0-based from the start bit) on which rx_ack is raised
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int ack_idx,
                              input int max_ticks);
        logic [FRAME_BITS-1:0] fr;
        fr = {stop_b, d, 1'b0};
        for (int i = 0; i < FRAME_BITS * OVERSAMPLE && i < max_ticks; i++) begin
            do_tick(fr[i / OVERSAMPLE], (i == ack_idx));
        end
    endtask

    task automatic line_ticks(input logic b, input int n);
        for (int i = 0; i < n; i++) do_tick(b, 1'b0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] m_data;
        logic       m_done;
        logic       m_ferr;
        logic       m_oerr;
        logic [7:0] rd;
        logic       rstop;
        logic       rack;

        total       = 0;
        bad         = 0;
        gaps_en     = 1'b0;
        nrst        = 1'b1;
        sample_tick = 1'b0;
        bit_in      = 1'b1;
        rx_ack      = 1'b0;

        tbl[0] = '{8'hD3, 1'b1, 1'b0, 8'hD3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h55, 1'b0, 1'b1, 8'hD3, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0};

        #3 nrst = 1'b0;
        #1 chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        line_ticks(1'b1, 4);

        // Table of back-to-back frames, one tick per clock
        for (int k = 0; k < 8; k++) begin
            if (tbl[k].ack_before) pulse_ack();
            send_frame(tbl[k].d, tbl[k].stop_b, -1, FRAME_BITS * OVERSAMPLE);
            if (!tbl[k].stop_b) line_ticks(1'b0, 20);
            idle_cycle();
            chk_all($sformatf("tbl%0d", k), tbl[k].e_data, tbl[k].e_done, tbl[k].e_ferr,
                    tbl[k].e_oerr, tbl[k].e_busy);
            if (!tbl[k].stop_b) begin
                line_ticks(1'b1, 6);
                idle_cycle();
                chk($sformatf("tbl%0d.busy_after_break", k), 32'(busy), 32'(0));
            end
            line_ticks(1'b1, 2);
        end

        // Ack clears rx_done one cycle later and leaves the data alone
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        chk_all("ack_clear", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);

        // Glitch: line low for 4 ticks only
        line_ticks(1'b0, 4);
        idle_cycle();
        chk("glitch.busy_in_start", 32'(busy), 32'(1));
        line_ticks(1'b1, 12);
        idle_cycle();
        chk_all("glitch", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);

        // Ack lands on the completion edge of the second frame (tick 154)
        send_frame(8'h11, 1'b1, -1, FRAME_BITS * OVERSAMPLE);
        line_ticks(1'b1, 2);
        idle_cycle();
        chk_all("collide.first", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, (FRAME_BITS - 1) * OVERSAMPLE + OVERSAMPLE / 2 + 2,
                   FRAME_BITS * OVERSAMPLE);
        idle_cycle();
        chk_all("collide", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_ack();
        line_ticks(1'b1, 2);

        // Randomized frames with irregular tick spacing against a frame-level model
        gaps_en = 1'b1;
        m_data  = 8'h81;
        m_done  = 1'b0;
        m_ferr  = 1'b0;
        m_oerr  = 1'b0;
        for (int k = 0; k < 24; k++) begin
            rd    = 8'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            rack  = ($urandom_range(0, 2) == 0);
            if (rack) begin
                pulse_ack();
                m_done = 1'b0;
                m_ferr = 1'b0;
                m_oerr = 1'b0;
            end
            send_frame(rd, rstop, -1, FRAME_BITS * OVERSAMPLE);
            if (rstop) begin
                if (m_done) m_oerr = 1'b1;
                m_data = rd;
                m_done = 1'b1;
            end else begin
                m_ferr = 1'b1;
                line_ticks(1'b0, 8);
            end
            idle_cycle();
            chk_all($sformatf("rnd%0d", k), m_data, m_done, m_ferr, m_oerr, !rstop);
            line_ticks(1'b1, rstop ? 2 : 6);
            idle_cycle();
            chk($sformatf("rnd%0d.idle", k), 32'(busy), 32'(0));
        end
        gaps_en = 1'b0;

        // Reset in the middle of the data bits, then a clean frame
        send_frame(8'hD3, 1'b1, -1, 50);
        @(negedge clk);
        sample_tick = 1'b0;
        nrst        = 1'b0;
        #1 chk_all("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        line_ticks(1'b1, 4);
        send_frame(8'h5A, 1'b1, -1, FRAME_BITS * OVERSAMPLE);
        idle_cycle();
        chk_all("after_reset", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
